// File: rtl/writeback_stage_pkg.sv
// Shared widths, depth default and helpers for the writeback stage.
package writeback_stage_pkg;

    localparam int MAX_LENGTH    = 32;  // data width
    localparam int REG_LENGTH    = 5;   // register index width
    localparam int REGF_LENGTH   = 32;  // number of architectural registers
    localparam int WB_FIFO_DEPTH = 4;   // default EX result FIFO depth

    // Which source loads the output register this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_EX   = 2'd3
    } wb_src_e;

    // One-hot decode of a register index into a busy-mask contribution.
    function automatic logic [REGF_LENGTH-1:0] reg_onehot(input logic [REG_LENGTH-1:0] idx);
        logic [REGF_LENGTH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/writeback_stage_wb_fifo.sv
// Small synchronous FIFO holding EX results (dest + value) waiting for the
// register-file write port. Also reports which registers it has pending.
module wb_fifo
    import writeback_stage_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [REG_LENGTH-1:0]      push_dest,
    input  logic [MAX_LENGTH-1:0]      push_value,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [REG_LENGTH-1:0]      head_dest,
    output logic [MAX_LENGTH-1:0]      head_value,
    output logic [REGF_LENGTH-1:0]     busy_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [DEPTH-1:0]       r_valid;
    logic [REG_LENGTH-1:0]  r_dest  [DEPTH];
    logic [MAX_LENGTH-1:0]  r_value [DEPTH];
    logic [REGF_LENGTH-1:0] w_entry_mask [DEPTH];
    logic                   w_push;
    logic                   w_pop;

    // Ignore requests that would overflow or underflow; push into a full
    // FIFO is only legal when the same cycle also pops.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    assign full       = (r_count == FULL_COUNT);
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign head_dest  = r_dest[r_rd_ptr];
    assign head_value = r_value[r_rd_ptr];

    // Pointers, count and per-entry valid flags; pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr          <= r_rd_ptr + PW'(1);
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr          <= r_wr_ptr + PW'(1);
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry payload storage; contents are meaningless unless the valid flag is set.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dest[r_wr_ptr]  <= push_dest;
            r_value[r_wr_ptr] <= push_value;
        end
    end

    // Each valid entry contributes the one-hot of its destination.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_mask
        assign w_entry_mask[gi] = r_valid[gi] ? reg_onehot(r_dest[gi]) : '0;
    end

    // Fold the per-entry contributions into the FIFO's busy mask.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_mask = busy_mask | w_entry_mask[i];
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: merges ALU (EX) and load (MEM) results onto the single
// register-file write port, buffering EX results, and exports a busy mask.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic                   ex_wb_en,
    input  logic [REG_LENGTH-1:0]  ex_dest,
    input  logic [MAX_LENGTH-1:0]  ex_value,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [REG_LENGTH-1:0]  mem_dest,
    input  logic [MAX_LENGTH-1:0]  mem_value,
    output logic                   write_enabled,
    output logic [REG_LENGTH-1:0]  destination_source,
    output logic [MAX_LENGTH-1:0]  writing_value,
    output logic [REGF_LENGTH-1:0] busy_mask
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CAPACITY = CW'(DEPTH);

    logic                   r_write_enabled;
    logic [REG_LENGTH-1:0]  r_dest;
    logic [MAX_LENGTH-1:0]  r_value;

    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [CW-1:0]          w_fifo_count;
    logic [REG_LENGTH-1:0]  w_head_dest;
    logic [MAX_LENGTH-1:0]  w_head_value;
    logic [REGF_LENGTH-1:0] w_fifo_mask;
    logic                   w_ex_write;
    logic                   w_mem_write;
    logic                   w_push;
    logic                   w_pop;
    wb_src_e                w_src;

    // MEM waits while the FIFO is at capacity (so EX cannot be starved) or
    // while an older queued EX write targets the same register.
    assign mem_ready = reset && (w_fifo_count < CAPACITY) && !w_fifo_mask[mem_dest];

    // Transfers that actually produce a register write; r0 and non-writing
    // EX results are consumed and dropped.
    assign w_mem_write = mem_valid && mem_ready && (mem_dest != '0);
    assign w_ex_write  = ex_valid && ex_ready && ex_wb_en && (ex_dest != '0);

    // Pick the output-register source: MEM, then FIFO head, then EX bypass.
    always_comb begin
        w_src = SRC_NONE;
        if (w_mem_write) begin
            w_src = SRC_MEM;
        end else if (!w_fifo_empty) begin
            w_src = SRC_FIFO;
        end else if (w_ex_write) begin
            w_src = SRC_EX;
        end
    end

    assign w_pop    = (w_src == SRC_FIFO);
    assign w_push   = w_ex_write && (w_src != SRC_EX);
    assign ex_ready = reset && (!w_fifo_full || w_pop);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_dest  (ex_dest),
        .push_value (ex_value),
        .pop        (w_pop),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty),
        .count      (w_fifo_count),
        .head_dest  (w_head_dest),
        .head_value (w_head_value),
        .busy_mask  (w_fifo_mask)
    );

    // Output register feeding the register file; index/data hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write_enabled <= 1'b0;
            r_dest          <= '0;
            r_value         <= '0;
        end else begin
            r_write_enabled <= (w_src != SRC_NONE);
            case (w_src)
                SRC_MEM: begin
                    r_dest  <= mem_dest;
                    r_value <= mem_value;
                end
                SRC_FIFO: begin
                    r_dest  <= w_head_dest;
                    r_value <= w_head_value;
                end
                SRC_EX: begin
                    r_dest  <= ex_dest;
                    r_value <= ex_value;
                end
                default: ;
            endcase
        end
    end

    assign write_enabled      = r_write_enabled;
    assign destination_source = r_dest;
    assign writing_value      = r_value;
    assign busy_mask          = w_fifo_mask | (r_write_enabled ? reg_onehot(r_dest) : '0);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage: hand-computed vectors, one line per transaction.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_wb_en = 1'b0;
    logic [4:0]  ex_dest = '0;
    logic [31:0] ex_value = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_dest = '0;
    logic [31:0] mem_value = '0;
    logic        write_enabled;
    logic [4:0]  destination_source;
    logic [31:0] writing_value;
    logic [31:0] busy_mask;

    int n_checks = 0;
    int n_errors = 0;

    writeback_stage #(.DEPTH(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .ex_valid           (ex_valid),
        .ex_ready           (ex_ready),
        .ex_wb_en           (ex_wb_en),
        .ex_dest            (ex_dest),
        .ex_value           (ex_value),
        .mem_valid          (mem_valid),
        .mem_ready          (mem_ready),
        .mem_dest           (mem_dest),
        .mem_value          (mem_value),
        .write_enabled      (write_enabled),
        .destination_source (destination_source),
        .writing_value      (writing_value),
        .busy_mask          (busy_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid  = 1'b0;
        ex_wb_en  = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic offer_mem(input logic [4:0] d, input logic [31:0] v);
        mem_valid = 1'b1;
        mem_dest  = d;
        mem_value = v;
    endtask

    task automatic offer_ex(input logic wb, input logic [4:0] d, input logic [31:0] v);
        ex_valid = 1'b1;
        ex_wb_en = wb;
        ex_dest  = d;
        ex_value = v;
    endtask

    task automatic check_write(input string tag, input logic [4:0] d, input logic [31:0] v);
        check({tag, "_we"}, {31'b0, write_enabled}, 32'd1);
        check({tag, "_dest"}, {27'b0, destination_source}, {27'b0, d});
        check({tag, "_value"}, writing_value, v);
        $display("write  %s: r%0d = 0x%0h (we=%0b)", tag, destination_source, writing_value, write_enabled);
    endtask

    // Table for the burst test: per-cycle expected readies and expected writes.
    logic [6:0]  burst_mr = 7'b1001111;  // bit c = mem_ready in cycle c
    logic [4:0]  burst_dest [10] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20, 5'd21, 5'd14, 5'd22, 5'd23, 5'd24};
    logic [31:0] burst_val  [10] = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h100, 32'h101, 32'h204,
                                     32'h102, 32'h103, 32'h104};

    initial begin
        // ---------------- reset state ----------------
        #2;
        check("rst_we", {31'b0, write_enabled}, 32'd0);
        check("rst_dest", {27'b0, destination_source}, 32'd0);
        check("rst_value", writing_value, 32'd0);
        check("rst_busy", busy_mask, 32'd0);
        check("rst_ex_ready", {31'b0, ex_ready}, 32'd0);
        check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
        $display("reset  : outputs checked while reset low");
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rel_ex_ready", {31'b0, ex_ready}, 32'd1);
        check("rel_mem_ready", {31'b0, mem_ready}, 32'd1);
        $display("reset  : released");

        // ---------------- single MEM write ----------------
        offer_mem(5'd3, 32'h11);
        #1;
        check("t1_mem_ready", {31'b0, mem_ready}, 32'd1);
        tick();
        idle_inputs();
        check_write("t1", 5'd3, 32'h11);
        check("t1_busy", busy_mask, 32'h8);
        tick();
        check("t1_idle_we", {31'b0, write_enabled}, 32'd0);
        check("t1_idle_busy", busy_mask, 32'd0);
        check("t1_hold_dest", {27'b0, destination_source}, 32'd3);

        // ---------------- MEM and EX in the same cycle ----------------
        offer_mem(5'd4, 32'hA);
        offer_ex(1'b1, 5'd5, 32'hB);
        tick();
        idle_inputs();
        check_write("t2a", 5'd4, 32'hA);
        check("t2a_busy", busy_mask, 32'h30);  // r4 in output, r5 queued
        tick();
        check_write("t2b", 5'd5, 32'hB);
        check("t2b_busy", busy_mask, 32'h20);
        tick();
        check("t2_idle_we", {31'b0, write_enabled}, 32'd0);

        // ---------------- WAW ordering: queued EX r6 blocks MEM r6 ----------------
        offer_mem(5'd7, 32'h77);
        offer_ex(1'b1, 5'd6, 32'h1);
        tick();
        ex_valid = 1'b0;
        offer_mem(5'd6, 32'h2);
        #1;
        check_write("t3a", 5'd7, 32'h77);
        check("t3_mem_blocked", {31'b0, mem_ready}, 32'd0);
        tick();
        check_write("t3b", 5'd6, 32'h1);
        check("t3_mem_unblocked", {31'b0, mem_ready}, 32'd1);
        tick();
        idle_inputs();
        check_write("t3c", 5'd6, 32'h2);
        tick();
        check("t3_idle_we", {31'b0, write_enabled}, 32'd0);

        // ---------------- MEM stream plus 5 EX results, FIFO fills ----------------
        begin
            int m = 0;
            int x = 0;
            for (int c = 0; c <= 10; c++) begin
                mem_valid = 1'b0;
                ex_valid  = 1'b0;
                if (c <= 6 && m < 5) offer_mem(5'(10 + m), 32'h200 + 32'(m));
                if (x < 5) offer_ex(1'b1, 5'(20 + x), 32'h100 + 32'(x));
                #1;
                if (c <= 6) begin
                    check($sformatf("t4_c%0d_mem_ready", c), {31'b0, mem_ready}, {31'b0, burst_mr[c]});
                    check($sformatf("t4_c%0d_ex_ready", c), {31'b0, ex_ready}, 32'd1);
                end
                if (mem_valid && c <= 6 && burst_mr[c]) m++;
                if (ex_valid) x++;
                tick();
                idle_inputs();
                if (c < 10) begin
                    check_write($sformatf("t4_c%0d", c), burst_dest[c], burst_val[c]);
                end else begin
                    check("t4_drained_we", {31'b0, write_enabled}, 32'd0);
                    check("t4_drained_busy", busy_mask, 32'd0);
                end
            end
        end

        // ---------------- dropped transfers ----------------
        offer_ex(1'b0, 5'd8, 32'hDEAD);
        offer_mem(5'd0, 32'hBEEF);
        #1;
        check("t5_ex_ready", {31'b0, ex_ready}, 32'd1);
        check("t5_mem_ready", {31'b0, mem_ready}, 32'd1);
        tick();
        offer_ex(1'b1, 5'd0, 32'h1234);
        mem_valid = 1'b0;
        check("t5a_we", {31'b0, write_enabled}, 32'd0);
        check("t5a_busy", busy_mask, 32'd0);
        tick();
        idle_inputs();
        check("t5b_we", {31'b0, write_enabled}, 32'd0);
        check("t5b_busy", busy_mask, 32'd0);
        $display("drop   : wb_en=0, mem r0 and ex r0 consumed");

        // ---------------- async reset with 3 queued entries ----------------
        offer_mem(5'd1, 32'h1);
        offer_ex(1'b1, 5'd2, 32'h2);
        tick();
        offer_mem(5'd3, 32'h3);
        offer_ex(1'b1, 5'd9, 32'h9);
        tick();
        offer_mem(5'd11, 32'hB);
        offer_ex(1'b1, 5'd12, 32'hC);
        tick();
        idle_inputs();
        check_write("t6_pre", 5'd11, 32'hB);
        check("t6_pre_busy", busy_mask, 32'h1A04);
        reset = 1'b0;
        #1;
        check("t6_rst_we", {31'b0, write_enabled}, 32'd0);
        check("t6_rst_dest", {27'b0, destination_source}, 32'd0);
        check("t6_rst_value", writing_value, 32'd0);
        check("t6_rst_busy", busy_mask, 32'd0);
        check("t6_rst_ex_ready", {31'b0, ex_ready}, 32'd0);
        check("t6_rst_mem_ready", {31'b0, mem_ready}, 32'd0);
        $display("reset  : asserted with 3 entries queued");
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t6_post%0d_we", k), {31'b0, write_enabled}, 32'd0);
            check($sformatf("t6_post%0d_busy", k), busy_mask, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
